// File: rtl/prog_pkg.sv
// Shared constants, types and helpers for the program-store loader.
package prog_pkg;

    localparam int unsigned P_SIZE  = 6;
    localparam int unsigned I_SIZE  = 24;
    localparam int unsigned INSTR_W = I_SIZE + 1;
    localparam int unsigned BPW     = (INSTR_W + 7) / 8;
    localparam int unsigned WORD_W  = BPW * 8;
    localparam int unsigned DISC_W  = WORD_W - INSTR_W;

    // Bits of the leading byte that fall above the instruction MSB.
    localparam logic [7:0] DISC_MASK = 8'(8'hFF << (8 - DISC_W));

    typedef logic [I_SIZE:0]   instr_t;
    typedef logic [P_SIZE-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    function automatic logic first_byte_bad(input logic [7:0] b);
        return (b & DISC_MASK) != 8'h00;
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Big-endian byte-to-instruction shift register with a byte counter.
module word_assembler
    import prog_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic [7:0]         i_byte,
    output logic [INSTR_W-1:0] o_word_c,
    output logic               o_first_c,
    output logic               o_full_c
);

    localparam int unsigned CNT_W  = $clog2(BPW);
    localparam int unsigned KEEP_W = INSTR_W - 8;

    // Only the bits that can still reach the instruction are kept.
    logic [KEEP_W-1:0] r_word;
    logic [CNT_W-1:0]  r_cnt;

    assign o_word_c  = {r_word, i_byte};
    assign o_first_c = (r_cnt == '0);
    assign o_full_c  = i_shift && (r_cnt == CNT_W'(BPW - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_word <= o_word_c[KEEP_W-1:0];
            r_cnt  <= o_full_c ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Fills the program store from a host byte stream and holds the CPU until done.
module prog_loader
    import prog_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [P_SIZE:0]    count,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               wr_en,
    output logic [P_SIZE-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    loader_state_t r_state;
    loader_state_t w_next_state;

    logic               r_rx_ready;
    logic               r_wr_en;
    logic [P_SIZE-1:0]  r_wr_addr;
    logic [INSTR_W-1:0] r_wr_data;
    logic               r_cpu_hold;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [P_SIZE-1:0]  r_addr;
    logic [P_SIZE:0]    r_words_left;

    logic               w_start_ok;
    logic               w_accept;
    logic [INSTR_W-1:0] w_word;
    logic               w_first;
    logic               w_full;

    assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
    assign w_accept   = rx_valid && r_rx_ready;

    word_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_start_ok),
        .i_shift   (w_accept),
        .i_byte    (rx_data),
        .o_word_c  (w_word),
        .o_first_c (w_first),
        .o_full_c  (w_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next_state = (count == '0) ? DONE : RECV;
            RECV:       if (w_full) w_next_state = WRITE;
            WRITE:      w_next_state = (r_words_left == (P_SIZE+1)'(1)) ? DONE : RECV;
            default:    w_next_state = IDLE;
        endcase
    end

    // Datapath, counters and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_words_left <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        if (count == '0) begin
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                            r_busy     <= 1'b0;
                            r_rx_ready <= 1'b0;
                        end else begin
                            r_words_left <= count;
                            r_addr       <= '0;
                            r_done       <= 1'b0;
                            r_busy       <= 1'b1;
                            r_cpu_hold   <= 1'b1;
                            r_rx_ready   <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (w_accept && w_first && first_byte_bad(rx_data)) r_err <= 1'b1;
                    if (w_full) begin
                        r_rx_ready <= 1'b0;
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= r_addr;
                        r_wr_data  <= w_word;
                    end
                end
                WRITE: begin
                    r_addr       <= r_addr + P_SIZE'(1);
                    r_words_left <= r_words_left - (P_SIZE+1)'(1);
                    if (r_words_left == (P_SIZE+1)'(1)) begin
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_cpu_hold <= 1'b0;
                        r_rx_ready <= 1'b0;
                    end else begin
                        r_rx_ready <= 1'b1;
                    end
                end
                default: r_rx_ready <= 1'b0;
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_cpu_hold;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writer side of the program memory. The processor fetches 25-bit instructions by address from the program store; this block fills a writable program store from a byte stream delivered by the host link. It assembles bytes into instruction words, writes them to consecutive addresses from 0, and holds the CPU until the load completes.

Parameters:
p_size, 6, program address width; the store holds 1<<p_size words
i_size, 24, MSB index of an instruction; instruction width is i_size+1 = 25 bits
BPW, 4, bytes per word, derived as ceil((i_size+1)/8); not overridden

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE
count  in  p_size+1  number of words to load, 0..(1<<p_size); sampled with start
rx_data  in  8  stream byte
rx_valid  in  1  stream byte valid
rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid & rx_ready
wr_en  out  1  program store write strobe, one cycle per word
wr_addr  out  p_size  program store write address
wr_data  out  i_size+1  program store write data
cpu_hold  out  1  holds the processor in reset while high
busy  out  1  load in progress
done  out  1  last load completed
err  out  1  sticky format error for the current load

Behaviour:
- Reset (async, any state): state=IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, busy=0, done=0, err=0, byte and word counters=0.
- A reset during a load abandons it. Words already written stay in the store. done stays 0 and cpu_hold stays 1 until a later load completes.
- Registered outputs; the FSM states are IDLE, RECV, WRITE and DONE.
- IDLE or DONE with start=1:
  - count==0: go to DONE. done=1, cpu_hold=0, err=0. No writes.
  - Otherwise: go to RECV. Set words_left=count, addr=0, byte_cnt=0, err=0, done=0, busy=1, cpu_hold=1.
  - start is ignored in RECV and WRITE.
- RECV:
  - rx_ready=1.
  - Each accepted byte shifts into the assembly register, MSB-first (big-endian): the first byte carries bits [31:24] of a 32-bit word, and wr_data takes bits [i_size:0].
  - On the first byte of a word, if the discarded bits [31:i_size+1] (byte bits [7:1] at default) are nonzero, set err=1. err is sticky until the next start. The word is still written, truncated.
  - When the BPW-th byte is accepted, go to WRITE on the next edge. rx_ready drops the same edge.
  - rx_valid low stalls indefinitely with no timeout.
- WRITE:
  - Exactly one cycle with wr_en=1, wr_addr=addr, wr_data=assembled word; rx_ready=0.
  - Then addr increments and words_left decrements.
  - If words_left was 1, go to DONE. Otherwise go to RECV.
- DONE: busy=0, done=1, cpu_hold=0, rx_ready=0. Bytes offered here are not accepted.
- Latency: the write strobe appears 1 cycle after the edge that accepts the 4th byte. Peak throughput is 5 cycles per word.
- Wrap: count=(1<<p_size) writes addresses 0..(1<<p_size)-1. The address counter is p_size bits and wraps to 0 after the last write, which is harmless. The word counter is p_size+1 bits.
- wr_addr and wr_data hold their last values when wr_en=0.
- Unwritten store locations keep prior contents; the loader does not clear the store.

Decomposition:
- Shared package prog_pkg:
  - P_SIZE=6, I_SIZE=24, INSTR_W=I_SIZE+1, BPW
  - typedef instr_t (logic [I_SIZE:0]), addr_t (logic [P_SIZE-1:0])
  - loader state enum loader_state_t {IDLE, RECV, WRITE, DONE}
- One sub-module, word_assembler: shift register plus byte counter with load/clear and a word_full flag. prog_loader holds the FSM, address and word counters, and the status flags.

Test Plan:
1. Reset then idle → rx_ready=0, wr_en=0, cpu_hold=1, done=0, busy=0. Assert reset mid-load after 2 words → state IDLE, done=0, cpu_hold=1.
2. start, count=2. Bytes 00 12 34 56 and 01 AB CD EF, rx_valid held high → wr_en pulses at addr 0 with data 0x123456 and at addr 1 with data 0x1ABCDEF. Each pulse comes 1 cycle after its 4th byte. done=1, cpu_hold=0, err=0.
3. Same load with rx_valid toggling every other cycle → identical writes. No byte is lost or duplicated, and rx_ready=0 during WRITE.
4. start, count=0 → next cycle done=1, cpu_hold=0, no wr_en.
5. start, count=64 with words i → 64 writes, addresses 0..63, data=i. done only after address 63. start pulsed mid-load is ignored.
6. First byte 0x80 in word 0 → err=1, word written as 0x0xxxxxx truncated. err stays set through DONE and clears on the next start.
